// File: rtl/tour_cmd_if.sv
// Command-processor side of the tour sequencer: command/valid out, accept/complete back, response byte.
// The master (sequencer) drives cmd/cmd_rdy/resp; the slave (command processor) drives clr_cmd_rdy/send_resp.
interface tour_cmd_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        output cmd, cmd_rdy, resp,
        input  clr_cmd_rdy, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, resp,
        output clr_cmd_rdy, send_resp
    );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Splits each one-hot knight move into a vertical then horizontal command; UART pass-through when idle.
// cmd/cmd_rdy/resp are combinational; each leg is held until clr_cmd_rdy, then the next waits for send_resp.
module tour_cmd_sequencer (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [4:0]       mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    tour_cmd_if.master       cp
);
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;
    localparam logic [7:0] HD_NORTH   = 8'h00;
    localparam logic [7:0] HD_WEST    = 8'h3F;
    localparam logic [7:0] HD_SOUTH   = 8'h7F;
    localparam logic [7:0] HD_EAST    = 8'hBF;
    localparam logic [7:0] RESP_BUSY  = 8'hA5;
    localparam logic [7:0] RESP_DONE  = 8'h5A;
    localparam logic [4:0] LAST_MOVE  = 5'd23;

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    state_t      state, nxt_state;
    logic        inc_indx, clr_indx;
    logic        move_ok;
    logic        y_pos, y_two, x_pos, x_two;
    logic [15:0] vert_cmd, horz_cmd;

    // Leg decode straight from the move bits: sign and |offset| of each axis.
    assign y_pos   = move[0] | move[1] | move[2] | move[7];
    assign y_two   = move[0] | move[1] | move[4] | move[5];
    assign x_pos   = move[0] | move[5] | move[6] | move[7];
    assign x_two   = move[2] | move[3] | move[6] | move[7];
    assign move_ok = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);

    assign vert_cmd = {OP_MOVE, (y_pos ? HD_NORTH : HD_SOUTH), (y_two ? 4'd2 : 4'd1)};
    assign horz_cmd = {OP_FANFARE, (x_pos ? HD_EAST : HD_WEST), (x_two ? 4'd2 : 4'd1)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            state <= nxt_state;
            if (clr_indx)
                mv_indx <= 5'd0;
            else if (inc_indx)
                mv_indx <= mv_indx + 5'd1;
        end
    end

    always_comb begin
        nxt_state  = state;
        inc_indx   = 1'b0;
        clr_indx   = 1'b0;
        cp.cmd     = cmd_UART;
        cp.cmd_rdy = 1'b0;
        cp.resp    = RESP_BUSY;
        unique case (state)
            IDLE: begin
                cp.cmd_rdy = cmd_rdy_UART;
                cp.resp    = RESP_DONE;
                if (start_tour) begin
                    clr_indx  = 1'b1;
                    nxt_state = VERT;
                end
            end
            VERT: begin
                cp.cmd = vert_cmd;
                // A corrupt move never reaches the command processor.
                if (!move_ok) begin
                    cp.resp   = RESP_DONE;
                    nxt_state = IDLE;
                end else begin
                    cp.cmd_rdy = 1'b1;
                    if (cp.clr_cmd_rdy)
                        nxt_state = WAIT_V;
                end
            end
            WAIT_V: begin
                cp.cmd = vert_cmd;
                if (cp.send_resp)
                    nxt_state = HORZ;
            end
            HORZ: begin
                cp.cmd     = horz_cmd;
                cp.cmd_rdy = 1'b1;
                if (cp.clr_cmd_rdy)
                    nxt_state = WAIT_H;
            end
            WAIT_H: begin
                cp.cmd = horz_cmd;
                if (mv_indx == LAST_MOVE)
                    cp.resp = RESP_DONE;
                if (cp.send_resp) begin
                    if (mv_indx == LAST_MOVE) begin
                        nxt_state = IDLE;
                    end else begin
                        inc_indx  = 1'b1;
                        nxt_state = VERT;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tour_cmd_sequencer.sv
module tb_tour_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;

    tour_cmd_if cp ();

    tour_cmd_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cp           (cp.master)
    );

    always #5 clk = ~clk;

    // Solver model: move table indexed combinationally by mv_indx.
    logic [7:0] tour_bits [0:31];
    logic [7:0] fixed_move;
    logic       use_tour;
    assign move = use_tour ? tour_bits[mv_indx] : fixed_move;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] exp_v;
        logic [15:0] exp_h;
    } vec_t;
    vec_t vecs [8];

    int dx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [15:0] model_vert(input int k);
        int m;
        m = (dy[k] < 0) ? -dy[k] : dy[k];
        return {4'h2, (dy[k] > 0) ? 8'h00 : 8'h7F, 4'(m)};
    endfunction

    function automatic logic [15:0] model_horz(input int k);
        int m;
        m = (dx[k] < 0) ? -dx[k] : dx[k];
        return {4'h3, (dx[k] > 0) ? 8'hBF : 8'h3F, 4'(m)};
    endfunction

    // Runs one complete L-move from VERT back to the next VERT (or IDLE).
    task automatic one_move(input logic [15:0] ev, input logic [15:0] eh, input logic last, input string tag);
        chk({tag, " vert cmd"}, cp.cmd, ev);
        chk({tag, " vert rdy"}, {15'd0, cp.cmd_rdy}, 16'd1);
        cp.clr_cmd_rdy = 1'b1;
        tick();
        cp.clr_cmd_rdy = 1'b0;
        #1;
        chk({tag, " wait_v rdy"}, {15'd0, cp.cmd_rdy}, 16'd0);
        chk({tag, " wait_v resp"}, {8'd0, cp.resp}, 16'h00A5);
        cp.send_resp = 1'b1;
        tick();
        cp.send_resp = 1'b0;
        #1;
        chk({tag, " horz cmd"}, cp.cmd, eh);
        chk({tag, " horz rdy"}, {15'd0, cp.cmd_rdy}, 16'd1);
        cp.clr_cmd_rdy = 1'b1;
        tick();
        cp.clr_cmd_rdy = 1'b0;
        #1;
        chk({tag, " wait_h resp"}, {8'd0, cp.resp}, last ? 16'h005A : 16'h00A5);
        cp.send_resp = 1'b1;
        tick();
        cp.send_resp = 1'b0;
        #1;
    endtask

    task automatic begin_tour();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        #1;
    endtask

    // Backtracking knight's tour on 5x5 from (2,2), standing in for the solver.
    task automatic solve_tour();
        bit vis [5][5];
        int px [25];
        int py [25];
        int choice [25];
        int depth, nx, ny, iter;
        bit found;
        foreach (vis[i, j]) vis[i][j] = 1'b0;
        depth = 0; px[0] = 2; py[0] = 2; vis[2][2] = 1'b1; choice[0] = 0; iter = 0;
        while (depth < 24) begin
            iter++;
            if (iter > 5000000 || depth < 0) begin
                $display("FAIL solver: no tour found, depth %0d iterations %0d", depth, iter);
                $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
                $fatal(1);
            end
            found = 1'b0;
            for (int k = choice[depth]; k < 8 && !found; k++) begin
                nx = px[depth] + dx[k];
                ny = py[depth] + dy[k];
                if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && !vis[nx][ny]) begin
                    found = 1'b1;
                    tour_bits[depth] = 8'(1 << k);
                    choice[depth] = k + 1;
                    depth++;
                    px[depth] = nx; py[depth] = ny; vis[nx][ny] = 1'b1;
                    choice[depth] = 0;
                end
            end
            if (!found) begin
                vis[px[depth]][py[depth]] = 1'b0;
                depth--;
            end
        end
    endtask

    initial begin
        int ncmd, k;
        vecs[0] = '{8'h01, 16'h2002, 16'h3BF1};
        vecs[1] = '{8'h02, 16'h2002, 16'h33F1};
        vecs[2] = '{8'h04, 16'h2001, 16'h33F2};
        vecs[3] = '{8'h08, 16'h27F1, 16'h33F2};
        vecs[4] = '{8'h10, 16'h27F2, 16'h33F1};
        vecs[5] = '{8'h20, 16'h27F2, 16'h3BF1};
        vecs[6] = '{8'h40, 16'h27F1, 16'h3BF2};
        vecs[7] = '{8'h80, 16'h2001, 16'h3BF2};
        foreach (tour_bits[i]) tour_bits[i] = 8'h00;

        rst_n = 1'b0; start_tour = 1'b0; fixed_move = 8'h01; use_tour = 1'b0;
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        cp.clr_cmd_rdy = 1'b0; cp.send_resp = 1'b0;
        #2;
        chk("reset mv_indx", {11'd0, mv_indx}, 16'd0);
        chk("reset resp", {8'd0, cp.resp}, 16'h005A);
        chk("reset cmd pass", cp.cmd, 16'h1234);
        chk("reset rdy pass", {15'd0, cp.cmd_rdy}, 16'd1);
        do_reset();

        // Each L-move in isolation; cmd_rdy_UART stays high and must be ignored.
        for (int i = 0; i < 8; i++) begin
            fixed_move = vecs[i].mv;
            begin_tour();
            chk("vec resp busy", {8'd0, cp.resp}, 16'h00A5);
            one_move(vecs[i].exp_v, vecs[i].exp_h, 1'b0, $sformatf("vec%0d", i));
            chk("vec mv_indx", {11'd0, mv_indx}, 16'd1);
            chk("vec next rdy", {15'd0, cp.cmd_rdy}, 16'd1);
            do_reset();
        end

        // clr and send together in VERT: only clr counts.
        fixed_move = 8'h01;
        begin_tour();
        cp.clr_cmd_rdy = 1'b1; cp.send_resp = 1'b1;
        tick();
        cp.clr_cmd_rdy = 1'b0; cp.send_resp = 1'b0;
        #1;
        chk("clr+send rdy", {15'd0, cp.cmd_rdy}, 16'd0);
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        #1;
        chk("still wait_v rdy", {15'd0, cp.cmd_rdy}, 16'd0);
        chk("start ignored idx", {11'd0, mv_indx}, 16'd0);
        cp.send_resp = 1'b1;
        tick();
        cp.send_resp = 1'b0;
        #1;
        chk("horz after 2nd send", cp.cmd, 16'h3BF1);
        chk("horz rdy", {15'd0, cp.cmd_rdy}, 16'd1);
        do_reset();

        // Reset in WAIT_H at mv_indx 7.
        fixed_move = 8'h01;
        begin_tour();
        for (int i = 0; i < 7; i++) one_move(16'h2002, 16'h3BF1, 1'b0, "pre7");
        chk("idx7", {11'd0, mv_indx}, 16'd7);
        cp.clr_cmd_rdy = 1'b1; tick(); cp.clr_cmd_rdy = 1'b0;
        cp.send_resp = 1'b1; tick(); cp.send_resp = 1'b0;
        cp.clr_cmd_rdy = 1'b1; tick(); cp.clr_cmd_rdy = 1'b0;
        #1;
        chk("wait_h7 resp", {8'd0, cp.resp}, 16'h00A5);
        rst_n = 1'b0;
        #1;
        chk("midreset idx", {11'd0, mv_indx}, 16'd0);
        chk("midreset resp", {8'd0, cp.resp}, 16'h005A);
        chk("midreset pass", cp.cmd, 16'h1234);
        tick();
        rst_n = 1'b1;
        #1;

        // Non-one-hot move aborts with no cmd_rdy.
        cmd_rdy_UART = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fixed_move = (i == 0) ? 8'h00 : 8'h03;
            begin_tour();
            chk("bad move rdy", {15'd0, cp.cmd_rdy}, 16'd0);
            chk("bad move resp", {8'd0, cp.resp}, 16'h005A);
            tick();
            cmd_UART = 16'h4321; #1;
            chk("bad move idle pass", cp.cmd, 16'h4321);
            chk("bad move idle rdy", {15'd0, cp.cmd_rdy}, 16'd0);
            cmd_UART = 16'h1234;
        end
        cmd_rdy_UART = 1'b1;

        // Full tour.
        solve_tour();
        use_tour = 1'b1;
        begin_tour();
        ncmd = 0;
        for (int i = 0; i < 24; i++) begin
            k = 0;
            for (int b = 0; b < 8; b++) if (tour_bits[i][b]) k = b;
            if (cp.cmd_rdy) ncmd++;
            one_move(model_vert(k), model_horz(k), i == 23, $sformatf("tour%0d", i));
            ncmd++;
        end
        chk("tour cmd count", 16'(ncmd), 16'd48);
        chk("tour end idx", {11'd0, mv_indx}, 16'd23);
        chk("tour end resp", {8'd0, cp.resp}, 16'h005A);
        cmd_UART = 16'h4000;
        #1;
        chk("post tour pass", cp.cmd, 16'h4000);
        chk("post tour rdy", {15'd0, cp.cmd_rdy}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
